// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared constants and helpers for the round-robin arbitrating mux
package rr_arb_mux_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// rtl/rr_arb_mux_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic [N_CH-1:0]               req,
    input  logic [clog2_min1(N_CH)-1:0]   ptr,
    output logic [N_CH-1:0]               gnt,
    output logic [clog2_min1(N_CH)-1:0]   gnt_idx
);

    localparam int PW = clog2_min1(N_CH);

    logic found;
    int   cand;

    // Walk the channels from ptr with wrap; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N_CH; i++) begin
            cand = (int'(ptr) + i) % N_CH;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin N:1 stream mux with a single registered output slot
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               in_valid,
    input  logic [N_CH*WIDTH-1:0]         in_data,
    output logic [N_CH-1:0]               in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_min1(N_CH)-1:0]   out_ch
);

    localparam int PW = clog2_min1(N_CH);

    logic [PW-1:0]    ptr;
    logic [N_CH-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] ch_data [N_CH];
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.N_CH(N_CH)) u_arbiter (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign sel_data = ch_data[gnt_idx];

    // The slot can take a word when empty or draining; reset masks the grant immediately.
    assign load     = ~out_valid | out_ready;
    assign in_ready = (rst_n && load) ? gnt : '0;
    assign take     = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
            ptr       <= (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8, data bits per channel; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  N_CH  per-channel request; bit i belongs to channel i.
REQ-006 in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  N_CH  per-channel accept; one-hot or zero.
REQ-008 out_valid  output  1  output register holds a word.
REQ-009 out_ready  input  1  downstream accepts the word this cycle.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_ch  output  $clog2(N_CH)  index of the channel that supplied out_data.

Function
REQ-012 Transfer on input channel i: in_valid[i] & in_ready[i] in the same cycle; output transfer: out_valid & out_ready.
REQ-013 load = ~out_valid | out_ready. Load is the slot-free condition: output empty, or draining this cycle.
REQ-014 The block SHALL assert in_ready[i] only when load=1, in_valid[i]=1 and channel i holds the grant; all other in_ready bits SHALL be 0.
REQ-015 Grant SHALL be round-robin. Search starts at pointer ptr and wraps modulo N_CH; the first channel with in_valid set wins.
REQ-016 After a transfer from channel k, ptr SHALL become (k+1) mod N_CH; wrap from N_CH-1 to 0.
REQ-017 ptr SHALL be unchanged in cycles with no input transfer.
REQ-018 On an input transfer from channel k, the next edge SHALL load out_data=in_data[k], out_ch=k and out_valid=1; latency is 1 cycle.
REQ-019 When load=1 and no in_valid is set, the next edge SHALL clear out_valid; out_data and out_ch SHALL hold their values.
REQ-020 While out_valid=1 and out_ready=0, out_valid, out_data and out_ch SHALL stay stable, and all in_ready SHALL be 0.
REQ-021 Simultaneous output drain and new input transfer in one cycle SHALL give back-to-back words with no bubble; full throughput is 1 word/cycle.
REQ-022 in_ready SHALL depend combinationally on in_valid, out_ready and state only; in_ready SHALL NOT depend on in_data.
REQ-023 A channel that drops in_valid without a transfer SHALL lose no state; arbitration SHALL re-evaluate each cycle.
REQ-024 Starvation bound: a continuously valid channel SHALL be granted within N_CH output transfers.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready all 0.
REQ-026 Reset asserted mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, channel 0 SHALL have highest priority for the first grant.

Structure
REQ-028 Package rr_arb_mux_pkg SHALL hold default constants N_CH_DEF=4 and WIDTH_DEF=8, plus function clog2_min1, which returns at least 1.
REQ-029 One sub-module, rr_arbiter, SHALL hold only combinational logic: inputs req[N_CH] and ptr; outputs one-hot gnt and index gnt_idx.
REQ-030 The data-select path SHALL be a parametrised N_CH:1 selection indexed by gnt_idx. The output register, ptr and load logic SHALL reside in rr_arb_mux.

Verification
REQ-031 Reset check: hold rst_n=0 with all in_valid=1 -> out_valid=0 and in_ready=0000; release -> in_ready=0001 on the first cycle.
REQ-032 Fairness test (N_CH=4, WIDTH=8): all in_valid=1, out_ready=1, in_data = {8'h44,8'h33,8'h22,8'h11} -> out_ch sequence 0,1,2,3,0 and out_data 11,22,33,44,11 on consecutive cycles.
REQ-033 Stall test: out_ready=0 for 3 cycles with a word held (ch2, data 8'hA5) -> out_data=A5 and out_ch=2 stable, in_ready=0000; out_ready=1 -> next word follows with no bubble.
REQ-034 Sparse test: only ch3 valid, then only ch1 valid -> grants 3 then 1, ptr wraps to 0 then moves to 2; idle cycle clears out_valid.
REQ-035 Async reset with out_valid=1 mid-stall -> out_valid=0 before the next clk edge; the next grant goes to ch0.
REQ-036 Randomised scoreboard check, N_CH=3, WIDTH=5, random valid/ready for 2000 cycles -> every accepted word appears once, in order, with correct out_ch; no channel waits more than 3 transfers.
